// File: rtl/memory_stream_reader_pkg.sv
// memory_stream_reader_pkg
//   Shared definitions for the memory stream engines.
//   msr_state_e : control states of the read engine (IDLE / STREAM / DONE).
//                 The encoding is kept stable so a future writer engine can reuse it.
package memory_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } msr_state_e;

endpackage

// File: rtl/memory_stream_reader_stream_buffer2.sv
// memory_stream_reader_stream_buffer2
//   2-entry synchronous FIFO holding words returned by the memory until the
//   stream sink accepts them. All updates are gated by clock_enable.
//   Ports:
//     clock, reset_n : clock and asynchronous active-low reset
//     clock_enable   : gates every state update
//     push           : write push_data this edge
//     push_data      : word to store
//     pop            : drop the head word this edge (ignored when empty)
//     occupancy      : number of stored words (0..2)
//     head_data      : oldest stored word
module memory_stream_reader_stream_buffer2 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clock_enable,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occupancy,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] entry0_r;
    logic [WIDTH-1:0] entry1_r;
    logic             rd_ptr_r;
    logic             wr_ptr_r;
    logic [1:0]       count_r;
    logic             push_fire_s;
    logic             pop_fire_s;

    assign push_fire_s = clock_enable & push;
    assign pop_fire_s  = clock_enable & pop & (count_r != 2'd0);

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry0_r <= {WIDTH{1'b0}};
            entry1_r <= {WIDTH{1'b0}};
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_fire_s) begin
                if (wr_ptr_r == 1'b0) begin
                    entry0_r <= push_data;
                end else begin
                    entry1_r <= push_data;
                end
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_fire_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_fire_s, pop_fire_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign occupancy = count_r;
    assign head_data = rd_ptr_r ? entry1_r : entry0_r;

    memory_stream_reader_stream_buffer2_checker u_checker (
        .clock     (clock),
        .reset_n   (reset_n),
        .push_fire (push_fire_s),
        .pop_fire  (pop_fire_s),
        .count     (count_r)
    );

endmodule

// File: rtl/memory_stream_reader_stream_buffer2_checker.sv
// memory_stream_reader_stream_buffer2_checker
//   Property checker for the 2-entry output buffer.
//   Ports:
//     clock, reset_n : buffer clock and asynchronous active-low reset
//     push_fire      : a word is written on this edge
//     pop_fire       : the head word leaves on this edge
//     count          : current occupancy (0..2)
module memory_stream_reader_stream_buffer2_checker (
    input logic       clock,
    input logic       reset_n,
    input logic       push_fire,
    input logic       pop_fire,
    input logic [1:0] count
);

    // A push into a full buffer is only legal when the head leaves on the same edge.
    assert property (@(posedge clock) disable iff (!reset_n)
        (push_fire && !pop_fire) |-> (count != 2'd2));

    // Occupancy never exceeds the two physical entries.
    assert property (@(posedge clock) disable iff (!reset_n)
        count != 2'd3);

endmodule

// File: rtl/memory_stream_reader.sv
// memory_stream_reader
//   Read-side engine for a dual-port memory on the same clock. Takes a
//   (start address, length) command, issues one read per cycle to the memory
//   and streams the returned words on a valid/ready interface, marking the
//   final word with out_last. A 2-entry buffer plus an in-flight flag hides
//   the memory's 1-cycle read latency so full throughput survives backpressure.
//   Ports:
//     clock, reset_n   : clock (also the memory read clock), async active-low reset
//     clock_enable     : gates all state updates; tie to memory read_clock_enable
//     start_valid/ready, start_addr, start_length : command handshake (length 0 legal)
//     mem_read_enable, mem_read_addr, mem_read_data : memory read port
//     out_valid/ready, out_data, out_last           : output stream
//     busy             : engine not idle
//     done             : one enabled-cycle pulse when a command completes
module memory_stream_reader
    import memory_stream_reader_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 512,
    parameter int LENGTH_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clock_enable,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [$clog2(DEPTH)-1:0] start_addr,
    input  logic [LENGTH_WIDTH-1:0]  start_length,
    output logic                     mem_read_enable,
    output logic [$clog2(DEPTH)-1:0] mem_read_addr,
    input  logic [WIDTH-1:0]         mem_read_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]           ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0]           ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LENGTH_WIDTH-1:0] LEN_ZERO  = {LENGTH_WIDTH{1'b0}};
    localparam logic [LENGTH_WIDTH-1:0] LEN_ONE   = {{(LENGTH_WIDTH-1){1'b0}}, 1'b1};

    msr_state_e              state_r;
    msr_state_e              state_s;
    logic [AW-1:0]           addr_r;
    logic [LENGTH_WIDTH-1:0] remaining_r;
    logic [LENGTH_WIDTH-1:0] length_r;
    logic [LENGTH_WIDTH-1:0] sent_r;
    logic                    inflight_r;

    logic                    accept_s;
    logic                    pop_s;
    logic                    pop_fire_s;
    logic                    issue_s;
    logic [2:0]              pending_s;
    logic [1:0]              occupancy_s;
    logic [WIDTH-1:0]        head_data_s;

    // Next read address, wrapping to 0 after the last memory location.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == ADDR_LAST) ? {AW{1'b0}} : (a + ADDR_ONE);
    endfunction

    assign accept_s   = clock_enable & start_valid & (state_r == ST_IDLE);
    assign pop_s      = out_valid & out_ready;
    assign pop_fire_s = pop_s & clock_enable;

    // Words that will sit in the buffer after this edge if nothing new is
    // issued: a word leaving this cycle frees a slot immediately, which is
    // what lets a full buffer keep one read per cycle going.
    assign pending_s = {1'b0, occupancy_s} + {2'b00, inflight_r} - {2'b00, pop_s};

    assign issue_s = clock_enable & (state_r == ST_STREAM) &
                     (remaining_r != LEN_ZERO) & (pending_s < 3'd2);

    // Control state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; transitions only happen on enabled edges.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (start_length == LEN_ZERO) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_STREAM;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (pop_fire_s && out_last) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            ST_DONE: begin
                if (clock_enable) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Command counters: read address, reads still to issue, words already sent.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_r      <= {AW{1'b0}};
            remaining_r <= LEN_ZERO;
            length_r    <= LEN_ZERO;
            sent_r      <= LEN_ZERO;
        end else if (accept_s) begin
            addr_r      <= start_addr;
            remaining_r <= start_length;
            length_r    <= start_length;
            sent_r      <= LEN_ZERO;
        end else begin
            if (issue_s) begin
                addr_r      <= next_addr(addr_r);
                remaining_r <= remaining_r - LEN_ONE;
            end
            if (pop_fire_s) begin
                sent_r <= sent_r + LEN_ONE;
            end
        end
    end

    // In-flight flag: the memory returns data one enabled edge after an issue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_r <= 1'b0;
        end else if (clock_enable) begin
            inflight_r <= issue_s;
        end
    end

    memory_stream_reader_stream_buffer2 #(
        .WIDTH (WIDTH)
    ) u_buffer (
        .clock        (clock),
        .reset_n      (reset_n),
        .clock_enable (clock_enable),
        .push         (inflight_r),
        .push_data    (mem_read_data),
        .pop          (pop_s),
        .occupancy    (occupancy_s),
        .head_data    (head_data_s)
    );

    assign start_ready     = (state_r == ST_IDLE);
    assign busy            = (state_r != ST_IDLE);
    assign done            = (state_r == ST_DONE);
    assign mem_read_enable = issue_s;
    assign mem_read_addr   = addr_r;
    assign out_valid       = (occupancy_s != 2'd0);
    assign out_data        = head_data_s;
    // The head word's index equals the number of words already sent.
    assign out_last        = out_valid & (sent_r == (length_r - LEN_ONE));

endmodule

// File: tb/tb_memory_stream_reader.sv
// tb_memory_stream_reader
//   Self-checking bench for memory_stream_reader. A behavioural memory
//   (mem[i] = i[7:0], 1-cycle read latency, gated by clock_enable) sits on the
//   read port. Expected stream words come from the command: word k is
//   mem[(addr + k) mod 512].
module tb_memory_stream_reader;

    localparam int DEPTH = 512;

    logic       clock;
    logic       reset_n;
    logic       clock_enable;
    logic       start_valid;
    logic       start_ready;
    logic [8:0] start_addr;
    logic [9:0] start_length;
    logic       mem_read_enable;
    logic [8:0] mem_read_addr;
    logic [7:0] mem_read_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:DEPTH-1];

    memory_stream_reader #(
        .WIDTH        (8),
        .DEPTH        (DEPTH),
        .LENGTH_WIDTH (10)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .clock_enable    (clock_enable),
        .start_valid     (start_valid),
        .start_ready     (start_ready),
        .start_addr      (start_addr),
        .start_length    (start_length),
        .mem_read_enable (mem_read_enable),
        .mem_read_addr   (mem_read_addr),
        .mem_read_data   (mem_read_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural memory read port.
    always @(posedge clock) begin
        if (clock_enable && mem_read_enable) begin
            mem_read_data <= mem[mem_read_addr];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_start_ready"}, 32'(start_ready), 1);
        check({tag, "_busy"},        32'(busy), 0);
        check({tag, "_done"},        32'(done), 0);
        check({tag, "_out_valid"},   32'(out_valid), 0);
        check({tag, "_out_last"},    32'(out_last), 0);
        check({tag, "_out_data"},    32'(out_data), 0);
        check({tag, "_mem_rd_en"},   32'(mem_read_enable), 0);
    endtask

    // Runs one command. rmode: 0 ready always, 1 ready pattern 1,0,0,..., 2 random.
    // cemode: 0 clock_enable always high, 1 random (about 75% high).
    task automatic run_cmd(input int addr, input int len, input int rmode, input int cemode,
                           output int first_w, output int last_w, output int done_idx);
        int k, issued, idx, budget, first_valid_idx, exp_w;
        bit finished, seen_done, done_prev_en, prev_stall, xfer;
        logic [7:0] prev_data;
        k = 0; issued = 0; idx = 0; first_valid_idx = -1;
        finished = 1'b0; seen_done = 1'b0; done_prev_en = 1'b0; prev_stall = 1'b0;
        prev_data = 8'h00; first_w = -1; last_w = -1; done_idx = -1;
        budget = 40 * len + 60;

        @(negedge clock);
        start_valid  = 1'b1;
        start_addr   = 9'(addr);
        start_length = 10'(len);
        clock_enable = 1'b1;
        out_ready    = 1'b1;
        #1 check("start_ready_before_cmd", 32'(start_ready), 1);
        @(negedge clock);
        start_valid = 1'b0;

        while (!finished && idx < budget) begin
            if (cemode == 0) clock_enable = 1'b1;
            else clock_enable = ($urandom_range(0, 3) != 0);
            if (rmode == 0) out_ready = 1'b1;
            else if (rmode == 1) out_ready = ((idx % 3) == 0);
            else out_ready = 1'($urandom_range(0, 1));
            #1;
            if (done_prev_en) begin
                check("done_single_pulse", 32'(done), 0);
                check("start_ready_after_done", 32'(start_ready), 1);
                check("busy_after_done", 32'(busy), 0);
                finished = 1'b1;
            end else begin
                check("busy_during_cmd", 32'(busy), 1);
                check("start_ready_low_during_cmd", 32'(start_ready), 0);
                if (!clock_enable) check("rd_en_gated_by_ce", 32'(mem_read_enable), 0);
                if (mem_read_enable) begin
                    check("rd_addr", 32'(mem_read_addr), (addr + issued) % DEPTH);
                    issued++;
                    if (issued > len) check("too_many_issues", issued, len);
                end
                if (prev_stall) begin
                    check("stall_valid_held", 32'(out_valid), 1);
                    check("stall_data_held", 32'(out_data), 32'(prev_data));
                end
                if (out_valid) begin
                    if (first_valid_idx < 0) begin
                        first_valid_idx = idx;
                        if (cemode == 0) check("first_valid_latency", idx, 2);
                    end
                    check("out_last", 32'(out_last), (k == len - 1) ? 1 : 0);
                end else begin
                    check("out_last_without_valid", 32'(out_last), 0);
                end
                if (done && !seen_done) begin
                    seen_done = 1'b1;
                    done_idx = idx;
                    check("done_after_all_words", k, len);
                end
                xfer = clock_enable && out_valid && out_ready;
                if (xfer) begin
                    exp_w = ((addr + k) % DEPTH) & 255;
                    check("out_data", 32'(out_data), exp_w);
                    if (k == 0) first_w = 32'(out_data);
                    last_w = 32'(out_data);
                    k++;
                end
                prev_stall   = out_valid && !xfer;
                prev_data    = out_data;
                done_prev_en = done && clock_enable;
            end
            idx++;
            if (!finished) @(negedge clock);
        end
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_timeout: addr=%0d len=%0d words=%0d, command did not complete within %0d cycles", addr, len, k, budget);
        end
        check("words_received", k, len);
        check("reads_issued", issued, len);
    endtask

    typedef struct {
        int addr;
        int len;
        int rmode;
        int cemode;
        int exp_first;
        int exp_last;
        int exp_done_idx;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int fw, lw, di;
        int ra, rl, rr, rc;

        for (int i = 0; i < DEPTH; i++) mem[i] = i[7:0];

        vecs[0] = '{addr: 5,   len: 4,   rmode: 0, cemode: 0, exp_first: 8'h05, exp_last: 8'h08, exp_done_idx: 6};
        vecs[1] = '{addr: 510, len: 4,   rmode: 0, cemode: 0, exp_first: 8'hFE, exp_last: 8'h01, exp_done_idx: 6};
        vecs[2] = '{addr: 0,   len: 0,   rmode: 0, cemode: 0, exp_first: 0,     exp_last: 0,     exp_done_idx: 0};
        vecs[3] = '{addr: 20,  len: 6,   rmode: 1, cemode: 0, exp_first: 8'h14, exp_last: 8'h19, exp_done_idx: -1};
        vecs[4] = '{addr: 0,   len: 512, rmode: 0, cemode: 1, exp_first: 8'h00, exp_last: 8'hFF, exp_done_idx: -1};
        vecs[5] = '{addr: 300, len: 512, rmode: 2, cemode: 1, exp_first: 8'h2C, exp_last: 8'h2B, exp_done_idx: -1};
        vecs[6] = '{addr: 511, len: 1,   rmode: 0, cemode: 0, exp_first: 8'hFF, exp_last: 8'hFF, exp_done_idx: 3};
        vecs[7] = '{addr: 100, len: 3,   rmode: 2, cemode: 0, exp_first: 8'h64, exp_last: 8'h66, exp_done_idx: -1};

        reset_n      = 1'b0;
        clock_enable = 1'b0;
        start_valid  = 1'b0;
        start_addr   = 9'd0;
        start_length = 10'd0;
        out_ready    = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        clock_enable = 1'b1;
        @(negedge clock);
        #1 check_reset_values("post_reset_idle");

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].addr, vecs[i].len, vecs[i].rmode, vecs[i].cemode, fw, lw, di);
            if (vecs[i].len > 0) begin
                check($sformatf("vec%0d_first_word", i), fw, vecs[i].exp_first);
                check($sformatf("vec%0d_last_word", i), lw, vecs[i].exp_last);
            end
            if (vecs[i].exp_done_idx >= 0) begin
                check($sformatf("vec%0d_done_cycle", i), di, vecs[i].exp_done_idx);
            end
        end

        // Reset in the middle of a stalled command: buffered words must be dropped.
        @(negedge clock);
        start_valid  = 1'b1;
        start_addr   = 9'd40;
        start_length = 10'd10;
        clock_enable = 1'b1;
        out_ready    = 1'b0;
        @(negedge clock);
        start_valid = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        check("abort_buffer_holding", 32'(out_valid), 1);
        check("abort_head_word", 32'(out_data), 8'h28);
        reset_n = 1'b0;
        #1 check_reset_values("mid_cmd_reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("no_done_after_abort", 32'(done), 0);
        check("idle_after_abort", 32'(start_ready), 1);
        run_cmd(0, 2, 0, 0, fw, lw, di);
        check("after_abort_first_word", fw, 0);
        check("after_abort_last_word", lw, 1);
        check("after_abort_done_cycle", di, 4);

        // Random commands checked against the address-arithmetic model.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom_range(0, DEPTH - 1);
            rl = $urandom_range(0, 40);
            rr = $urandom_range(0, 2);
            rc = $urandom_range(0, 1);
            run_cmd(ra, rl, rr, rc, fw, lw, di);
            if (rl > 0) begin
                check("rand_first_word", fw, ra & 255);
                check("rand_last_word", lw, ((ra + rl - 1) % DEPTH) & 255);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
